// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Holds the FSM state encoding, default geometry, and the stop-decision offset helper.
// The helper is also used by the bench to predict when a frame completes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // Edges from the IDLE detect edge (t0) to the stop-bit decision edge.
    function automatic int stop_offset(input int os, input int data_bits, input int parity_bits);
        return 1 + (1 + data_bits + parity_bits) * os + os / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, edge flop, and 3-sample mid-bit majority voter.
// Latency: line seen 2 cycles late; vote is valid combinationally while cnt == M+1.
// Backpressure: none, free-running on every baud_clk edge.
// Ports: uart_rx (async line), cnt (sample counter from the FSM);
//        rxs (synced line), fall_det (rxs_d=1 and rxs=0), vote (majority of rxs at M-1, M, M+1).
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          baud_clk,
    input  logic          rst_n,
    input  logic          uart_rx,
    input  logic [CW-1:0] cnt,
    output logic          rxs,
    output logic          fall_det,
    output logic          vote
);
    localparam int M = OVERSAMPLE / 2;

    logic meta;
    logic rxs_d;
    logic smp_a;
    logic smp_b;

    // Everything resets to the idle level so a line low at release reads as one falling edge.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            meta  <= uart_rx;
            rxs   <= meta;
            rxs_d <= rxs;
            if (cnt == CW'(M - 1)) smp_a <= rxs;
            if (cnt == CW'(M))     smp_b <= rxs;
        end
    end

    assign fall_det = rxs_d & ~rxs;
    // Third sample is the live rxs on the cnt == M+1 edge.
    assign vote     = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 (optionally 8E1/8O1) serial receiver oversampling uart_rx, delivering bytes via a one-entry holding register.
// Latency: byte/errors visible after t0 + stop_offset(OVERSAMPLE, DATA_BITS, P) edges (154 by default).
// Backpressure: rx_valid/rx_ready; a good frame arriving while rx_valid is held drops the byte and pulses overrun_err.
// Ports: baud_clk, rst_n (async active-low), uart_rx (serial in), rx_data/rx_valid/rx_ready (holding register),
//        rx_busy (not IDLE), frame_err/overrun_err/parity_err (one-cycle pulses).
// Build option: define UART_RX_PARITY_EN to add a parity bit; otherwise parity_err is tied to 0.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  fall_det;
    logic                  vote;
    logic                  mid;
    logic                  last;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit;
`endif

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_sampler (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .cnt      (cnt),
        .rxs      (),
        .fall_det (fall_det),
        .vote     (vote)
    );

    assign mid     = (cnt == CW'(M + 1));
    assign last    = (cnt == CW'(OVERSAMPLE - 1));
    assign rx_busy = (state != IDLE);

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
            // A load in STOP below overrides this clear on the same edge.
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            cnt <= last ? '0 : cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (fall_det) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (mid && vote) begin
                        state <= IDLE;               // glitch: start bit did not hold to mid-bit
                    end else if (last) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (mid) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (last) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid)  par_bit <= vote;
                    if (last) state   <= STOP;
                end
`endif
                STOP: begin
                    // Decide at mid stop bit and leave at once so a back-to-back start edge is caught.
                    if (mid) begin
                        state <= IDLE;
                        if (!vote) begin
                            frame_err <= 1'b1;
                        end else begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            parity_err <= (par_bit != (^shreg ^ PARITY_ODD));
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;
    import uart_pkg::*;

    localparam int OS = OVERSAMPLE_DEF;
    localparam int DB = DATA_BITS_DEF;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam bit PAR_ODD = 1'b0;
    // From the edge after which the line is driven low: 3 edges to t0, then the stop offset.
    localparam int LAT = 3 + stop_offset(OS, DB, P);

    localparam int EV_DATA = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;
    localparam int EV_PAR  = 4;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       flip;
        int         kind;
        logic [7:0] held;
    } vec_t;

    logic       baud_clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   valid_hi = 0;
    logic prev_valid = 1'b0;
    ev_t  exp_q[$];
    vec_t vecs[7];

    uart_rx_oversample dut (
        .baud_clk    (baud_clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 baud_clk = ~baud_clk;
    always @(posedge baud_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic got(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_data", int'(rx_data), int'(e.data));
    endtask

    // Output monitor: sampled on the falling edge, away from DUT updates.
    always @(negedge baud_clk) begin
        if (rst_n) begin
            if (rx_valid && !prev_valid) got(EV_DATA);
            if (frame_err)               got(EV_FERR);
            if (overrun_err)             got(EV_OVR);
            if (parity_err)              got(EV_PAR);
            if (rx_valid)                valid_hi++;
        end
        prev_valid = rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic flip);
        logic par;
        uart_rx = 1'b0;
        idle(OS);
        for (int b = 0; b < DB; b++) begin
            uart_rx = d[b];
            idle(OS);
        end
        par = ^d ^ PAR_ODD ^ flip;
        if (P == 1) begin
            uart_rx = par;
            idle(OS);
        end
        uart_rx = stop;
        idle(OS);
        uart_rx = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge baud_clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int e0;
        vecs[0] = '{8'h55, 1'b1, 1'b0, EV_DATA, 8'h55};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, EV_FERR, 8'h55};
        vecs[2] = '{8'h00, 1'b1, 1'b0, EV_DATA, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, EV_DATA, 8'hFF};
        vecs[4] = '{8'h81, 1'b0, 1'b1, EV_FERR, 8'hFF};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, EV_DATA, 8'hA5};
        vecs[6] = '{8'hA5, 1'b1, 1'b0, EV_DATA, 8'hA5};

        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        idle(3);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_busy", rx_busy, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_ovr", overrun_err, 0);
        chk("reset_perr", parity_err, 0);
        rst_n = 1'b1;
        idle(20);

        // Table-driven frames, consumer always ready.
        for (int i = 0; i < 7; i++) begin
            valid_hi = 0;
            e0 = cyc;
            exp_q.push_back('{vecs[i].kind, vecs[i].held, e0 + LAT});
            if (P == 1 && vecs[i].flip && vecs[i].stop)
                exp_q.push_back('{EV_PAR, vecs[i].held, e0 + LAT});
            send(vecs[i].data, vecs[i].stop, vecs[i].flip);
            drain(200);
            idle(2 * OS);
            chk("hold_data", rx_data, vecs[i].held);
            chk("valid_width", valid_hi, (vecs[i].kind == EV_DATA) ? 1 : 0);
        end

        // Short low glitch: START rejects it at cnt = M+1, no output.
        valid_hi = 0;
        e0 = cyc;
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(6);
        chk("glitch_busy_mid", rx_busy, 1);
        idle(2);
        chk("glitch_busy_before_reject", rx_busy, 1);
        idle(1);
        chk("glitch_busy_after_reject", rx_busy, 0);
        idle(2 * OS);
        chk("glitch_no_valid", valid_hi, 0);

        // Back-to-back frames with consumer stalled: second one overruns.
        rx_ready = 1'b0;
        e0 = cyc;
        exp_q.push_back('{EV_DATA, 8'h11, e0 + LAT});
        send(8'h11, 1'b1, 1'b0);
        e0 = cyc;
        exp_q.push_back('{EV_OVR, 8'h11, e0 + LAT});
        send(8'h22, 1'b1, 1'b0);
        drain(200);
        idle(OS);
        chk("overrun_held_data", rx_data, 8'h11);
        chk("overrun_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        idle(1);
        chk("handshake_clears_valid", rx_valid, 0);
        idle(OS);

        // Reset in the middle of a frame discards it.
        fork
            send(8'hF0, 1'b1, 1'b0);
            begin
                idle(60);
                chk("busy_before_reset", rx_busy, 1);
                rst_n = 1'b0;
                #1;
                chk("reset_mid_busy", rx_busy, 0);
                chk("reset_mid_data", rx_data, 0);
            end
        join
        idle(5);
        rst_n = 1'b1;
        idle(20);
        chk("post_reset_valid", rx_valid, 0);
        e0 = cyc;
        exp_q.push_back('{EV_DATA, 8'h0F, e0 + LAT});
        send(8'h0F, 1'b1, 1'b0);
        drain(200);
        idle(2 * OS);
        chk("post_reset_data", rx_data, 8'h0F);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
